// File: rtl/arcade_input_pkg.sv
// Shared scancodes, joystick bit positions and player-control types for the arcade input front end.
package arcade_input_pkg;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_CTRL  = 8'h14;
  localparam logic [7:0] SC_F1    = 8'h05;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_F2    = 8'h06;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_G     = 8'h34;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_T     = 8'h2C;

  // Pad bits [4:0] already line up with player_ctrl_t {fire,up,down,left,right}
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;
  localparam int JOY_COIN   = 7;

  typedef struct packed {
    logic fire;
    logic up;
    logic down;
    logic left;
    logic right;
  } player_ctrl_t;

  typedef struct packed {
    logic         p1_up;
    logic         p1_down;
    logic         p1_left;
    logic         p1_right;
    logic         p1_fire_space;
    logic         p1_fire_ctrl;
    logic         start1_f1;
    logic         start1_key;
    logic         start2_f2;
    logic         start2_key;
    logic         coin_5;
    logic         coin_6;
    player_ctrl_t p2;
    logic         test;
  } key_state_t;

  // Horizontal display: each output direction takes the input direction 90 degrees away
  function automatic player_ctrl_t remap(input player_ctrl_t c, input logic rot);
    player_ctrl_t r;
    r = c;
    if (rot) begin
      r.up    = c.left;
      r.down  = c.right;
      r.left  = c.down;
      r.right = c.up;
    end
    return r;
  endfunction

endpackage

// File: rtl/arcade_input_ctrl_coin_pulse_gen.sv
// Stretches a rising edge of the coin request into a fixed-length coin pulse; edges during a pulse are dropped.
module coin_pulse_gen #(
  parameter int COIN_PULSE_CYC = 200000,
  parameter int CNT_W          = 18
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  output logic pulse_o
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(COIN_PULSE_CYC);

  logic             req_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pulse_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (req_i && !req_prev_q) begin
      cnt_d = LOAD;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_prev_q <= 1'b0;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
    end else begin
      req_prev_q <= req_i;
      cnt_q      <= cnt_d;
      pulse_q    <= (cnt_q != '0);
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/arcade_input_ctrl.sv
// Decodes PS/2 key events into held-key state, merges with both pads, applies rotation remap and drives coin pulse.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE_CYC = 200000,
  parameter int CNT_W          = 18
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  output logic [4:0]  p1_ctrl,
  output logic [4:0]  p2_ctrl,
  output logic        start1,
  output logic        start2,
  output logic        coin1,
  output logic        test
);

  logic         old_tog_q;
  logic         primed_q;
  logic         key_evt;
  logic         pressed;
  logic         ext;
  logic [7:0]   code;
  key_state_t   keys_q;
  key_state_t   keys_d;
  player_ctrl_t p1_keys;
  player_ctrl_t p1_d;
  player_ctrl_t p2_d;
  player_ctrl_t p1_q;
  player_ctrl_t p2_q;
  logic         start1_q;
  logic         start2_q;
  logic         test_q;
  logic         coin_req_q;
  logic         unused_ok;

  // primed_q blocks a false event when the toggle bit is already high at reset release
  assign key_evt = primed_q && (ps2_key[10] != old_tog_q);
  assign pressed = ps2_key[9];
  assign ext     = ps2_key[8];
  assign code    = ps2_key[7:0];

  always_comb begin
    keys_d = keys_q;
    if (key_evt) begin
      case (code)
        SC_UP:    keys_d.p1_up    = pressed;
        SC_DOWN:  keys_d.p1_down  = pressed;
        SC_LEFT:  keys_d.p1_left  = pressed;
        SC_RIGHT: keys_d.p1_right = pressed;
        SC_SPACE: if (!ext) keys_d.p1_fire_space = pressed;
        SC_CTRL:  if (!ext) keys_d.p1_fire_ctrl  = pressed;
        SC_F1:    if (!ext) keys_d.start1_f1     = pressed;
        SC_1:     if (!ext) keys_d.start1_key    = pressed;
        SC_F2:    if (!ext) keys_d.start2_f2     = pressed;
        SC_2:     if (!ext) keys_d.start2_key    = pressed;
        SC_5:     if (!ext) keys_d.coin_5        = pressed;
        SC_6:     if (!ext) keys_d.coin_6        = pressed;
        SC_R:     if (!ext) keys_d.p2.up         = pressed;
        SC_F:     if (!ext) keys_d.p2.down       = pressed;
        SC_D:     if (!ext) keys_d.p2.left       = pressed;
        SC_G:     if (!ext) keys_d.p2.right      = pressed;
        SC_A:     if (!ext) keys_d.p2.fire       = pressed;
        SC_T:     if (!ext) keys_d.test          = pressed;
        default:  ;
      endcase
    end
  end

  always_comb begin
    p1_keys.fire  = keys_q.p1_fire_space | keys_q.p1_fire_ctrl;
    p1_keys.up    = keys_q.p1_up;
    p1_keys.down  = keys_q.p1_down;
    p1_keys.left  = keys_q.p1_left;
    p1_keys.right = keys_q.p1_right;
    p1_d = remap(player_ctrl_t'(p1_keys | joystick_0[4:0]), rotate);
    p2_d = remap(player_ctrl_t'(keys_q.p2 | joystick_1[4:0]), rotate);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      old_tog_q  <= 1'b0;
      primed_q   <= 1'b0;
      keys_q     <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      start1_q   <= 1'b0;
      start2_q   <= 1'b0;
      test_q     <= 1'b0;
      coin_req_q <= 1'b0;
    end else begin
      old_tog_q  <= ps2_key[10];
      primed_q   <= 1'b1;
      keys_q     <= keys_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      start1_q   <= keys_q.start1_f1 | keys_q.start1_key |
                    joystick_0[JOY_START1] | joystick_1[JOY_START1];
      start2_q   <= keys_q.start2_f2 | keys_q.start2_key |
                    joystick_0[JOY_START2] | joystick_1[JOY_START2];
      test_q     <= keys_q.test;
      coin_req_q <= keys_q.coin_5 | keys_q.coin_6 |
                    joystick_0[JOY_COIN] | joystick_1[JOY_COIN];
    end
  end

  coin_pulse_gen #(
    .COIN_PULSE_CYC (COIN_PULSE_CYC),
    .CNT_W          (CNT_W)
  ) u_coin (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .req_i   (coin_req_q),
    .pulse_o (coin1)
  );

  assign p1_ctrl = p1_q;
  assign p2_ctrl = p2_q;
  assign start1  = start1_q;
  assign start2  = start2_q;
  assign test    = test_q;

  assign unused_ok = ^{joystick_0[15:8], joystick_1[15:8]};

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl with a short coin pulse (8 clocks).
module tb_arcade_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  logic [4:0]  p1_ctrl;
  logic [4:0]  p2_ctrl;
  logic        start1;
  logic        start2;
  logic        coin1;
  logic        test;

  int   checks = 0;
  int   errors = 0;
  logic tog    = 1'b0;

  arcade_input_ctrl #(
    .COIN_PULSE_CYC (8),
    .CNT_W          (18)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .joystick_0 (joystick_0),
    .joystick_1 (joystick_1),
    .rotate     (rotate),
    .p1_ctrl    (p1_ctrl),
    .p2_ctrl    (p2_ctrl),
    .start1     (start1),
    .start2     (start2),
    .coin1      (coin1),
    .test       (test)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic key(input logic pr, input logic e0, input logic [7:0] sc);
    tog     = ~tog;
    ps2_key = {tog, pr, e0, sc};
  endtask

  task automatic measure(input int n, output int hi, output int pulses);
    logic prev;
    prev   = 1'b0;
    hi     = 0;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (coin1) hi++;
      if (coin1 && !prev) pulses++;
      prev = coin1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int hi, pl, h1, p1c, h2, p2c, n;
    logic prev;

    // Reset with the toggle bit already high
    reset      = 1'b1;
    tog        = 1'b1;
    ps2_key    = {1'b1, 1'b1, 1'b0, 8'h75};
    joystick_0 = '0;
    joystick_1 = '0;
    rotate     = 1'b0;
    tick(3);
    chk("rst_outs", {p1_ctrl, p2_ctrl, start1, start2, coin1, test}, 32'h0);
    reset = 1'b0;
    tick(4);
    chk("prime_p1", p1_ctrl, 5'b00000);
    chk("prime_all", {p2_ctrl, start1, start2, coin1, test}, 32'h0);

    // Arrow with E0, two-clock latency
    key(1'b1, 1'b1, 8'h75);
    tick();
    chk("up_lat1", p1_ctrl, 5'b00000);
    tick();
    chk("up_press", p1_ctrl, 5'b01000);
    key(1'b0, 1'b1, 8'h75);
    tick(2);
    chk("up_release", p1_ctrl, 5'b00000);
    rotate = 1'b1;
    key(1'b1, 1'b1, 8'h75);
    tick(2);
    chk("rot_up_right", p1_ctrl, 5'b00001);
    key(1'b0, 1'b1, 8'h75);
    tick(2);
    chk("rot_release", p1_ctrl, 5'b00000);
    rotate = 1'b0;

    // Fire keys: E0 variant ignored, two keys OR'ed
    key(1'b1, 1'b1, 8'h29);
    tick(2);
    chk("e0_space_ign", p1_ctrl, 5'b00000);
    key(1'b1, 1'b0, 8'h29);
    tick(2);
    chk("space_fire", p1_ctrl, 5'b10000);
    key(1'b1, 1'b0, 8'h14);
    tick();
    key(1'b0, 1'b0, 8'h29);
    tick(2);
    chk("ctrl_holds_fire", p1_ctrl, 5'b10000);
    key(1'b0, 1'b0, 8'h14);
    tick(2);
    chk("fire_release", p1_ctrl, 5'b00000);
    key(1'b1, 1'b0, 8'h15);
    tick(2);
    chk("unlisted", {p1_ctrl, p2_ctrl, start1, start2, coin1, test}, 32'h0);

    // P2 keyboard and combinational rotation
    key(1'b1, 1'b0, 8'h2D);
    tick(2);
    chk("p2_key_up", p2_ctrl, 5'b01000);
    rotate = 1'b1;
    tick();
    chk("p2_key_rot", p2_ctrl, 5'b00001);
    rotate = 1'b0;
    key(1'b0, 1'b0, 8'h2D);
    tick(2);
    chk("p2_key_rel", p2_ctrl, 5'b00000);

    // Start / test keys and pad start
    key(1'b1, 1'b0, 8'h05);
    tick();
    key(1'b1, 1'b0, 8'h2C);
    tick(2);
    chk("start1_test", {start1, start2, test}, 3'b101);
    key(1'b0, 1'b0, 8'h05);
    tick();
    key(1'b0, 1'b0, 8'h2C);
    tick(2);
    chk("start_test_rel", {start1, start2, test}, 3'b000);
    joystick_1[6] = 1'b1;
    tick();
    chk("j1_start2", {start1, start2}, 2'b01);
    joystick_1[6] = 1'b0;

    // Pads: one-clock latency, rotation per player
    rotate        = 1'b1;
    joystick_1[1] = 1'b1;
    tick();
    chk("j1_left_rot", p2_ctrl, 5'b01000);
    chk("j1_p1_clean", p1_ctrl, 5'b00000);
    rotate     = 1'b0;
    joystick_1 = '0;
    joystick_0 = 16'h0014;
    tick();
    chk("j0_straight", p1_ctrl, 5'b10100);
    chk("j0_p2_clean", p2_ctrl, 5'b00000);
    joystick_0 = '0;
    tick(2);

    // Coin key held for 50 clocks
    key(1'b1, 1'b0, 8'h2E);
    measure(50, hi, pl);
    chk("coin_hold_hi", hi, 8);
    chk("coin_hold_pulses", pl, 1);
    key(1'b0, 1'b0, 8'h2E);
    tick(15);

    // Pad coin edges: second edge mid-pulse dropped, later edge honoured
    h1 = 0; p1c = 0; h2 = 0; p2c = 0;
    prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      joystick_0[7] = (i == 0) || (i == 20);
      joystick_1[7] = (i == 3);
      tick();
      if (i < 20) begin
        if (coin1) h1++;
        if (coin1 && !prev) p1c++;
      end else begin
        if (coin1) h2++;
        if (coin1 && !prev) p2c++;
      end
      prev = coin1;
    end
    joystick_0 = '0;
    joystick_1 = '0;
    chk("coin_j_hi1", h1, 8);
    chk("coin_j_pulses1", p1c, 1);
    chk("coin_j_hi2", h2, 8);
    chk("coin_j_pulses2", p2c, 1);
    tick(5);

    // Reset in the middle of a pulse
    joystick_0[7] = 1'b1;
    tick();
    joystick_0[7] = 1'b0;
    n = 0;
    while (!coin1 && n < 10) begin
      tick();
      n++;
    end
    chk("coin_rst_start", coin1, 1'b1);
    tick(4);
    chk("coin_rst_mid", coin1, 1'b1);
    reset = 1'b1;
    #1;
    chk("coin_rst_async", coin1, 1'b0);
    tick(2);
    reset = 1'b0;
    measure(20, hi, pl);
    chk("coin_rst_after", hi, 0);
    chk("rst_after_outs", {p1_ctrl, p2_ctrl, start1, start2, test}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
